sar_search_ctrl: RTL

- Successive-approximation search engine. It is the initiator side of the 3-bit one-hot magnitude-compare interface {a>b, a==b, a<b} = {100, 010, 001}.
- It drives probe values onto the comparator's b operand and reads back the compare code. The comparator's a operand is an unknown value.
- It binary-searches the value of a and reports it, with a step count and an error flag.
- Sits between control logic and any DataCompare-style comparator, which may be combinational or registered.

---
 rtl/sar_search_ctrl_pkg.sv | 16 +
 rtl/sar_search_ctrl_step_unit.sv | 49 ++++
 rtl/sar_search_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sar_search_ctrl_pkg.sv
// rtl/sar_search_ctrl_pkg.sv - compare codes and FSM encoding for the SAR search engine
package sar_search_ctrl_pkg;

  // One-hot magnitude-compare codes, shared with the comparator blocks.
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/sar_search_ctrl_step_unit.sv
// rtl/sar_search_ctrl_step_unit.sv - combinational narrowing step of the binary search
module sar_step_unit
  import sar_search_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W:0]   i_lo,
  input  logic [W:0]   i_hi,
  input  logic [2:0]   i_code,
  output logic [W:0]   o_lo,
  output logic [W:0]   o_hi,
  output logic [W-1:0] o_probe,
  output logic         o_eq,
  output logic         o_fault
);

  localparam logic [W:0] LIMIT = {1'b0, {W{1'b1}}};
  localparam logic [W:0] ONE   = {{W{1'b0}}, 1'b1};

  logic [W:0] w_cur;
  logic [W:0] w_nxt;

  assign w_cur = i_lo + ((i_hi - i_lo) >> 1);

  always_comb begin
    o_lo    = i_lo;
    o_hi    = i_hi;
    o_eq    = 1'b0;
    o_fault = 1'b0;
    case (i_code)
      CMP_GT: begin
        if (w_cur == LIMIT) o_fault = 1'b1;
        else                o_lo    = w_cur + ONE;
      end
      CMP_LT: begin
        if (w_cur == '0) o_fault = 1'b1;
        else             o_hi    = w_cur - ONE;
      end
      CMP_EQ:  o_eq    = 1'b1;
      default: o_fault = 1'b1;
    endcase
    // Crossed bounds mean the comparator gave contradictory answers.
    if (!o_eq && !o_fault && (o_lo > o_hi)) o_fault = 1'b1;
  end

  assign w_nxt   = o_lo + ((o_hi - o_lo) >> 1);
  assign o_probe = w_nxt[W-1:0];

endmodule

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - SAR search initiator; SAR_TIMEOUT_EN adds a compare-wait timeout
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int W = 8
`ifdef SAR_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iStart,
  output logic         oBusy,
  output logic [W-1:0] oProbe,
  output logic         oProbeValid,
  input  logic [2:0]   iCmp,
  input  logic         iCmpValid,
  output logic [W-1:0] oResult,
  output logic [3:0]   oSteps,
  output logic         oDone,
  output logic         oErr
);

  localparam logic [W:0]   LIMIT       = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0] FIRST_PROBE = {1'b0, {(W-1){1'b1}}};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W:0]   r_lo;
  logic [W:0]   r_hi;
  logic [W:0]   w_lo_nxt;
  logic [W:0]   w_hi_nxt;
  logic [W-1:0] r_probe;
  logic [W-1:0] w_probe_nxt;
  logic [W-1:0] r_result;
  logic [3:0]   r_cnt;
  logic [3:0]   r_steps;
  logic         w_eq;
  logic         w_fault;
  logic         w_start;
  logic         w_hs;

`ifdef SAR_TIMEOUT_EN
  localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] r_wait;
  logic              w_expire;
`endif

  sar_step_unit #(.W(W)) u_step (
    .i_lo    (r_lo),
    .i_hi    (r_hi),
    .i_code  (iCmp),
    .o_lo    (w_lo_nxt),
    .o_hi    (w_hi_nxt),
    .o_probe (w_probe_nxt),
    .o_eq    (w_eq),
    .o_fault (w_fault)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_hs        = 1'b0;
`ifdef SAR_TIMEOUT_EN
    w_expire    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          w_start     = 1'b1;
          w_state_nxt = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (iCmpValid) begin
          w_hs = 1'b1;
          if (w_fault)   w_state_nxt = ST_ERR;
          else if (w_eq) w_state_nxt = ST_DONE;
        end
`ifdef SAR_TIMEOUT_EN
        else if (r_wait == WAIT_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_ERR;
        end
`endif
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_lo     <= '0;
      r_hi     <= '0;
      r_probe  <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_steps  <= '0;
    end else if (w_start) begin
      r_lo    <= '0;
      r_hi    <= LIMIT;
      r_probe <= FIRST_PROBE;
      r_cnt   <= '0;
    end else if (w_hs) begin
      r_cnt <= r_cnt + 4'd1;
      if (w_fault || w_eq) r_steps <= r_cnt + 4'd1;
      if (w_eq) r_result <= r_probe;
      // Bounds only move while the search continues; a failed step leaves them frozen.
      if (!w_fault && !w_eq) begin
        r_lo    <= w_lo_nxt;
        r_hi    <= w_hi_nxt;
        r_probe <= w_probe_nxt;
      end
    end
`ifdef SAR_TIMEOUT_EN
    else if (w_expire) begin
      r_steps <= r_cnt;
    end
`endif
  end

`ifdef SAR_TIMEOUT_EN
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)                     r_wait <= '0;
    else if (w_start || w_hs)        r_wait <= '0;
    else if (r_state == ST_PROBE)    r_wait <= r_wait + 1'b1;
  end
`endif

  assign oBusy       = (r_state == ST_PROBE);
  assign oProbeValid = (r_state == ST_PROBE);
  assign oDone       = (r_state == ST_DONE);
  assign oErr        = (r_state == ST_ERR);
  assign oProbe      = r_probe;
  assign oResult     = r_result;
  assign oSteps      = r_steps;

endmodule
